regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- Parametrised successor to the 8-bit computer's 32x8 register file.
- Provides two independent synchronous read ports and one write port, all on a single rising clock edge.
- Adds write-to-read bypass, an asynchronous active-low reset, and a sequential clear engine that zeroes the array after reset or on request.
- Sits between the control unit/ALU and the datapath as the CPU's general register store.

Parameters:
- DATA_W, 8, width of each register in bits.
- ADDR_W, 5, address width.
- DEPTH, 32, number of registers implemented. Must satisfy 2 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rd0_addr  input  ADDR_W  read port 0 address.
- rd0_data  output  DATA_W  read port 0 data, registered.
- rd1_addr  input  ADDR_W  read port 1 address.
- rd1_data  output  DATA_W  read port 1 data, registered.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- clr  input  1  single-cycle request to zero the whole array.
- busy  output  1  high while the clear engine runs.
- wr_drop  output  1  one-cycle pulse when a write is discarded.

Behaviour:
- Reset:
  - Asynchronous, active low: reset_n low immediately forces rd0_data=0, rd1_data=0, wr_drop=0, busy=1, FSM=CLEAR, clear pointer=0.
  - The array itself is not reset asynchronously.
- FSM states:
  - CLEAR: each cycle writes 0 to array[ptr] and increments ptr. When ptr==DEPTH-1 the final zero is written, the FSM goes to IDLE and busy drops to 0 on the next edge. CLEAR therefore lasts exactly DEPTH cycles.
  - IDLE: clr=1 sampled on an edge moves the FSM to CLEAR with ptr=0 and busy=1 from that edge. clr while already in CLEAR is ignored; it does not restart the sweep.
- Reads:
  - Latency is 1 cycle: rdN_data at edge k+1 reflects rdN_addr sampled at edge k.
  - Both ports are fully independent and may use the same address.
  - Out of range (addr >= DEPTH): returns 0.
  - While busy=1: both ports return 0.
- Writes:
  - Performed on the rising edge when wr_en=1, FSM=IDLE and wr_addr < DEPTH.
  - If wr_en=1 while busy=1, or wr_addr >= DEPTH: the write is discarded and wr_drop=1 for the following cycle.
  - The cycle in which clr is sampled in IDLE: a concurrent write is discarded, wr_drop pulses, and clear takes priority.
- Bypass (write-first): if a write commits on the same edge a read port samples the same address, that port returns wr_data, not the stale value. This applies to each port independently.
- Reset mid-operation: reset_n asserted during CLEAR or IDLE restarts CLEAR from ptr=0 after deassertion. Partial contents are never exposed, because reads return 0 until busy=0.
- No negedge logic and no combinational read path.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- When defined:
  - Register 0 is hardwired to zero and writes to address 0 are silently discarded (wr_drop stays 0).
  - Reads of address 0 always return 0, including the bypass case.
  - The clear engine still sweeps addresses 0..DEPTH-1, so the duration is unchanged.
- When undefined: register 0 is an ordinary storage location.

Test Plan:
- Reset and clear: pulse reset_n low then high. busy must be 1 for exactly 32 cycles, then 0. Reads of every address then return 0x00; wr_drop stays 0 throughout.
- Write then read: write 0xA5 to addr 3; next cycle set rd0_addr=3 and rd1_addr=3. Both ports show 0xA5 one cycle later. Read addr 4 returns 0x00.
- Bypass: addr 7 holds 0x11; write 0x3C to addr 7 with rd0_addr=7 on the same edge. rd0_data must be 0x3C, not 0x11.
- Clear with a concurrent write: fill addrs 0-31 with nonzero values; assert clr together with wr_en (addr 5, 0xFF). wr_drop pulses and busy is high for 32 cycles. Afterwards all reads return 0x00, including addr 5.
- Reset mid-clear: assert reset_n low at cycle 10 of a clear. After release, busy stays high for a full 32 cycles from restart, and rd outputs stay 0 throughout.
- Zero register (REGFILE_ZERO_REG_EN defined): write 0x77 to addr 0. Reading addr 0 returns 0x00, including same-edge bypass, and wr_drop is 0. Without the macro, the read returns 0x77.

Source files
------------

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised general register store with two registered read
// ports and one write port, all on the rising edge of clk.
//
// A sequential clear engine zeroes the array after reset and on a clr request.
// While it runs, busy is high, reads return zero and writes are discarded.
// Discarded writes raise wr_drop for one cycle.
//
// Reads are write-first: a write that commits on the same edge a read port
// samples the same address is forwarded to that port.
//
// Optional feature macro: REGFILE_ZERO_REG_EN. When it is defined, register 0
// is hardwired to zero, and writes to address 0 are silently ignored.
module regfile_2r1w #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    output logic              busy,
    output logic              wr_drop
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_take;
    logic              rd_block;
    logic              wr_legal;
    logic              wr_commit;
    logic              wr_silent;
    logic              drop_next;
    logic [DATA_W-1:0] rd0_next;
    logic [DATA_W-1:0] rd1_next;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    // Registered read value for one port: zero while clearing, out of range or
    // on the hardwired zero register, otherwise forwarded write data or array.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        if (rd_block || !in_range(a) || (ZERO_REG && (a == '0)))
            return '0;
        else if (wr_commit && (wr_addr == a))
            return wr_data;
        else
            return mem[a];
    endfunction

    assign busy = (state == ST_CLEAR);

    // Write qualification, drop detection and next read values.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        clr_take  = (state == ST_IDLE) && clr;
        rd_block  = (state == ST_CLEAR) || clr_take;
        wr_legal  = in_range(wr_addr) && !(ZERO_REG && (wr_addr == '0));
        wr_commit = wr_en && (state == ST_IDLE) && !clr && wr_legal;
        wr_silent = wr_en && (state == ST_IDLE) && !clr && ZERO_REG && (wr_addr == '0);
        drop_next = wr_en && !wr_commit && !wr_silent;
        rd0_next  = read_port(rd0_addr);
        rd1_next  = read_port(rd1_addr);
    end

    // Clear-engine FSM plus registered read data and drop pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) begin
            state    <= ST_CLEAR;
            ptr      <= '0;
            rd0_data <= '0;
            rd1_data <= '0;
            wr_drop  <= 1'b0;
        end else begin
            rd0_data <= rd0_next;
            rd1_data <= rd1_next;
            wr_drop  <= drop_next;
            case (state)
                ST_CLEAR: begin
                    if (ptr == LAST_PTR) begin
                        state <= ST_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Storage array: the clear sweep writes zeros, otherwise committed writes land here.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; the clear engine zeroes it and reads are blocked until it finishes.
        if (state == ST_CLEAR)
            mem[ptr] <= '0;
        else if (wr_commit)
            mem[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed testbench for regfile_2r1w (DATA_W=8, ADDR_W=5, DEPTH=32).
// Build with +define+REGFILE_ZERO_REG_EN to exercise the zero-register variant.
module tb_regfile_2r1w;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rd0_addr, rd1_addr, wr_addr;
    logic [7:0] rd0_data, rd1_data, wr_data;
    logic       wr_en, clr, busy, wr_drop;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [7:0] EXP_R0_77 = 8'h00;
    localparam logic [7:0] EXP_R0_01 = 8'h00;
`else
    localparam logic [7:0] EXP_R0_77 = 8'h77;
    localparam logic [7:0] EXP_R0_01 = 8'h01;
`endif

    regfile_2r1w #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd0_addr (rd0_addr),
        .rd0_data (rd0_data),
        .rd1_addr (rd1_addr),
        .rd1_data (rd1_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr      (clr),
        .busy     (busy),
        .wr_drop  (wr_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until busy falls (bounded); checks outputs stay quiet meanwhile.
    task automatic wait_clear(input string tag, input int drop_at, output int edges);
        edges = 0;
        for (int t = 1; t <= 100; t++) begin
            wr_en   = (t == drop_at);
            wr_addr = 5'd2;
            wr_data = 8'hEE;
            tick();
            wr_en = 1'b0;
            edges = t;
            n_cmp++;
            if (rd0_data !== 8'h00 || rd1_data !== 8'h00) begin
                $display("FAIL %s_rd_zero: got rd0=%h rd1=%h expected 00 00 at edge %0d", tag, rd0_data, rd1_data, t);
                n_fail++;
            end
            n_cmp++;
            if (wr_drop !== (t == drop_at)) begin
                $display("FAIL %s_wr_drop: got %b expected %b at edge %0d", tag, wr_drop, (t == drop_at), t);
                n_fail++;
            end
            if (busy !== 1'b1) break;
        end
        n_cmp++;
        if (edges !== 32 || busy !== 1'b0) begin
            $display("FAIL %s_busy_len: got %0d edges (busy=%b) expected 32 (busy=0)", tag, edges, busy);
            n_fail++;
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd0_addr = 5'(i);
            rd1_addr = 5'(31 - i);
            tick();
            n_cmp++;
            if (rd0_data !== 8'h00 || rd1_data !== 8'h00 || wr_drop !== 1'b0) begin
                $display("FAIL %s_read_zero: addr %0d got rd0=%h rd1=%h drop=%b expected 00 00 0",
                         tag, i, rd0_data, rd1_data, wr_drop);
                n_fail++;
            end
        end
    endtask

    task automatic write_one(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int edges;
        reset_n = 1'b0;
        rd0_addr = '0; rd1_addr = '0; wr_addr = '0; wr_data = '0;
        wr_en = 1'b0; clr = 1'b0;
        #2;
        n_cmp++;
        if (busy !== 1'b1 || rd0_data !== 8'h00 || rd1_data !== 8'h00 || wr_drop !== 1'b0) begin
            $display("FAIL reset_async: got busy=%b rd0=%h rd1=%h drop=%b expected 1 00 00 0",
                     busy, rd0_data, rd1_data, wr_drop);
            n_fail++;
        end
        tick();
        tick();
        reset_n = 1'b1;
        wait_clear("reset", 0, edges);
        read_all_zero("reset");
    endtask

    task automatic test_write_read();
        write_one(5'd3, 8'hA5);
        rd0_addr = 5'd3;
        rd1_addr = 5'd3;
        tick();
        n_cmp++;
        if (rd0_data !== 8'hA5 || rd1_data !== 8'hA5) begin
            $display("FAIL write_read_same: got rd0=%h rd1=%h expected a5 a5", rd0_data, rd1_data);
            n_fail++;
        end
        write_one(5'd9, 8'h5A);
        rd0_addr = 5'd4;
        rd1_addr = 5'd9;
        tick();
        n_cmp++;
        if (rd0_data !== 8'h00 || rd1_data !== 8'h5A) begin
            $display("FAIL write_read_indep: got rd0=%h rd1=%h expected 00 5a", rd0_data, rd1_data);
            n_fail++;
        end
    endtask

    task automatic test_bypass();
        write_one(5'd7, 8'h11);
        rd0_addr = 5'd7;
        rd1_addr = 5'd3;
        write_one(5'd7, 8'h3C);
        n_cmp++;
        if (rd0_data !== 8'h3C || rd1_data !== 8'hA5) begin
            $display("FAIL bypass_port0: got rd0=%h rd1=%h expected 3c a5", rd0_data, rd1_data);
            n_fail++;
        end
        rd0_addr = 5'd3;
        rd1_addr = 5'd7;
        write_one(5'd7, 8'h44);
        n_cmp++;
        if (rd0_data !== 8'hA5 || rd1_data !== 8'h44) begin
            $display("FAIL bypass_port1: got rd0=%h rd1=%h expected a5 44", rd0_data, rd1_data);
            n_fail++;
        end
        rd0_addr = 5'd7;
        tick();
        n_cmp++;
        if (rd0_data !== 8'h44 || wr_drop !== 1'b0) begin
            $display("FAIL bypass_stored: got rd0=%h drop=%b expected 44 0", rd0_data, wr_drop);
            n_fail++;
        end
    endtask

    task automatic test_zero_reg();
        rd0_addr = 5'd0;
        rd1_addr = 5'd0;
        write_one(5'd0, 8'h77);
        n_cmp++;
        if (rd0_data !== EXP_R0_77 || wr_drop !== 1'b0) begin
            $display("FAIL zero_reg_bypass: got rd0=%h drop=%b expected %h 0", rd0_data, wr_drop, EXP_R0_77);
            n_fail++;
        end
        tick();
        n_cmp++;
        if (rd1_data !== EXP_R0_77 || wr_drop !== 1'b0) begin
            $display("FAIL zero_reg_read: got rd1=%h drop=%b expected %h 0", rd1_data, wr_drop, EXP_R0_77);
            n_fail++;
        end
    endtask

    task automatic test_clear_with_write();
        int edges;
        for (int i = 0; i < 32; i++) write_one(5'(i), 8'(i + 1));
        rd0_addr = 5'd5;
        rd1_addr = 5'd31;
        tick();
        n_cmp++;
        if (rd0_data !== 8'h06 || rd1_data !== 8'h20) begin
            $display("FAIL fill_read: got rd0=%h rd1=%h expected 06 20", rd0_data, rd1_data);
            n_fail++;
        end
        rd1_addr = 5'd0;
        tick();
        n_cmp++;
        if (rd1_data !== EXP_R0_01) begin
            $display("FAIL fill_read_r0: got rd1=%h expected %h", rd1_data, EXP_R0_01);
            n_fail++;
        end
        clr = 1'b1;
        wr_en = 1'b1;
        wr_addr = 5'd5;
        wr_data = 8'hFF;
        tick();
        clr = 1'b0;
        wr_en = 1'b0;
        n_cmp++;
        if (wr_drop !== 1'b1 || busy !== 1'b1 || rd0_data !== 8'h00) begin
            $display("FAIL clr_start: got drop=%b busy=%b rd0=%h expected 1 1 00", wr_drop, busy, rd0_data);
            n_fail++;
        end
        clr = 1'b1;
        wait_clear("clear", 10, edges);
        clr = 1'b0;
        read_all_zero("clear");
    endtask

    task automatic test_reset_mid_clear();
        int edges;
        write_one(5'd20, 8'h99);
        rd0_addr = 5'd20;
        rd1_addr = 5'd20;
        tick();
        n_cmp++;
        if (rd0_data !== 8'h99 || rd1_data !== 8'h99) begin
            $display("FAIL pre_mid_read: got rd0=%h rd1=%h expected 99 99", rd0_data, rd1_data);
            n_fail++;
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (busy !== 1'b1 || rd0_data !== 8'h00) begin
            $display("FAIL mid_clear_state: got busy=%b rd0=%h expected 1 00", busy, rd0_data);
            n_fail++;
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || rd0_data !== 8'h00 || rd1_data !== 8'h00) begin
            $display("FAIL mid_reset_async: got busy=%b rd0=%h rd1=%h expected 1 00 00", busy, rd0_data, rd1_data);
            n_fail++;
        end
        #2;
        reset_n = 1'b1;
        wait_clear("mid_reset", 0, edges);
        tick();
        n_cmp++;
        if (rd0_data !== 8'h00 || rd1_data !== 8'h00) begin
            $display("FAIL mid_reset_after: got rd0=%h rd1=%h expected 00 00", rd0_data, rd1_data);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear_with_write();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
